// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and parameter helpers shared by the UART transmit path
// and the receiver that will reuse the same divisor arithmetic.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  function automatic int uart_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Truncating divide: the line rate error this introduces is accepted by design.
  function automatic int uart_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running 0..DIV-1 bit-period counter; restart realigns it so
// the next bit starts exactly on the cycle after restart.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (uart_clog2(DIV) < 1) ? 1 : uart_clog2(DIV);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart || (count == CW'(DIV - 1))) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == CW'(DIV - 1));

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by an internal word FIFO, frames sent back-to-back.
// Optional parity bit (and PARITY_ODD parameter) enabled by defining UART_PARITY_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
`ifdef UART_PARITY_EN
  ,parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD);
  localparam int AW  = uart_clog2(FIFO_DEPTH);
  localparam int BW  = uart_clog2(DATA_BITS);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [DATA_BITS-1:0] head;
  logic                 push, pop;

  uart_state_t          state, state_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 tick, restart, shift_en, stop_adv, frame_end, tx_next;
  logic                 last_bit, last_stop;
`ifdef UART_PARITY_EN
  logic                 parity_q;
`endif

  assign push        = wr_en && !full;
  assign wr_ptr_next = push ? wr_ptr + (AW + 1)'(1) : wr_ptr;
  assign rd_ptr_next = pop  ? rd_ptr + (AW + 1)'(1) : rd_ptr;
  assign head        = mem[rd_ptr[AW-1:0]];

  // Flags are registered from the next pointers so they are valid the cycle after a push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_next;
      rd_ptr   <= rd_ptr_next;
      full     <= (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                  (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
      empty    <= (wr_ptr_next == rd_ptr_next);
      overflow <= overflow | (wr_en & full);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  assign last_bit  = (bit_cnt == BW'(DATA_BITS - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    restart    = 1'b0;
    shift_en   = 1'b0;
    stop_adv   = 1'b0;
    frame_end  = 1'b0;
    tx_next    = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          restart    = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (tick) state_next = DATA;
      end
      DATA: begin
        tx_next = shift_reg[0];
        if (tick) begin
          shift_en = 1'b1;
`ifdef UART_PARITY_EN
          if (last_bit) state_next = PARITY;
`else
          if (last_bit) state_next = STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        tx_next = parity_q;
        if (tick) state_next = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (!last_stop) begin
            stop_adv = 1'b1;
          end else begin
            frame_end = 1'b1;
            if (!empty) begin
              pop        = 1'b1;
              restart    = 1'b1;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line outputs are registered one cycle behind the state so tx is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
`ifdef UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
      tx        <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      if (pop) begin
        shift_reg <= head;
        bit_cnt   <= '0;
        stop_cnt  <= 1'b0;
`ifdef UART_PARITY_EN
        parity_q  <= (^head) ^ PARITY_ODD;
`endif
      end else begin
        if (shift_en) begin
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= bit_cnt + 1'b1;
        end
        if (stop_adv) stop_cnt <= stop_cnt + 1'b1;
      end
      tx      <= tx_next;
      busy    <= (state != IDLE);
      tx_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of uart_tx_fifo at DIV=10, 8 data bits, 4-deep FIFO,
// plus a two-stop-bit instance. Build with UART_PARITY_EN to cover the parity bit.
module tb_uart_tx_fifo;

  localparam int DIV = 10;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
  localparam logic PRE_STOP_01 = 1'b1;
`else
  localparam int FB = 10;
  localparam logic PRE_STOP_01 = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, wr_en2;
  logic [7:0] wr_data, wr_data2;
  logic       full, empty, overflow, tx, busy, tx_done;
  logic       full2, empty2, overflow2, tx2, busy2, tx_done2;

  int compared = 0;
  int mismatched = 0;
  int done_count = 0;

  typedef struct {
    logic [7:0] data;
    logic       parity;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .overflow(overflow),
    .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  uart_tx_fifo #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .wr_data(wr_data2),
    .full(full2), .empty(empty2), .overflow(overflow2),
    .tx(tx2), .busy(busy2), .tx_done(tx_done2)
  );

  always @(negedge clk) begin
    if (rst_n && tx_done) done_count <= done_count + 1;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Called on a negedge; returns on the negedge just after the push edge.
  task automatic applyStimulus(input logic [7:0] data);
    wr_data = data;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Entered 3 cycles after the push/pop edge that starts the frame (tx low one cycle).
  // Samples every bit mid-period, checks the tx_done pulse, returns at the same
  // point of the following frame with the line value one cycle after tx_done.
  task automatic sampleFrame(input logic [7:0] data, input logic par, input string tag,
                             output logic next_tx);
    logic exp_bit;
    waitCycles(4);
    for (int i = 0; i < FB; i++) begin
      if (i > 0) waitCycles(DIV);
      if (i == 0)           exp_bit = 1'b0;
      else if (i <= 8)      exp_bit = data[i-1];
      else if (i == FB - 1) exp_bit = 1'b1;
      else                  exp_bit = par;
      checkOutput($sformatf("%s bit%0d", tag, i), tx, exp_bit);
    end
    waitCycles(3);
    checkOutput({tag, " tx_done early"}, tx_done, 1'b0);
    waitCycles(1);
    checkOutput({tx, " tx_done"} == "" ? tag : {tag, " tx_done"}, tx_done, 1'b1);
    checkOutput({tag, " busy at end"}, busy, 1'b1);
    checkOutput({tag, " stop level"}, tx, 1'b1);
    waitCycles(1);
    checkOutput({tag, " tx_done width"}, tx_done, 1'b0);
    next_tx = tx;
    waitCycles(1);
  endtask

  initial begin
    logic       nt;
    logic [4:0] full_seq;
    logic [4:0] ovf_seq;
    int         done_start;
    int         stray;

    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h03, 1'b0};
    vecs[3] = '{8'h80, 1'b1};
    vecs[4] = '{8'hFF, 1'b0};
    vecs[5] = '{8'h00, 1'b0};

    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; wr_en2 = 1'b0; wr_data2 = '0;
    waitCycles(2);
    $display("[TB] reset values");
    checkOutput("reset tx", tx, 1'b1);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset tx_done", tx_done, 1'b0);
    checkOutput("reset full", full, 1'b0);
    checkOutput("reset empty", empty, 1'b1);
    checkOutput("reset overflow", overflow, 1'b0);
    rst_n = 1'b1;
    waitCycles(2);

    $display("[TB] single-frame table");
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].data);
      checkOutput($sformatf("vec%0d empty after push", v), empty, 1'b0);
      waitCycles(1);
      checkOutput($sformatf("vec%0d tx before start", v), tx, 1'b1);
      checkOutput($sformatf("vec%0d empty after pop", v), empty, 1'b1);
      waitCycles(1);
      checkOutput($sformatf("vec%0d tx start fall", v), tx, 1'b0);
      checkOutput($sformatf("vec%0d busy rise", v), busy, 1'b1);
      waitCycles(1);
      sampleFrame(vecs[v].data, vecs[v].parity, $sformatf("vec%0d", v), nt);
      checkOutput($sformatf("vec%0d line idle after", v), nt, 1'b1);
      checkOutput($sformatf("vec%0d busy fall", v), busy, 1'b0);
      waitCycles(3);
    end

    $display("[TB] burst of four");
    done_start = done_count;
    wr_en = 1'b1; wr_data = 8'hA5; @(negedge clk);
    wr_data = 8'h3C; @(negedge clk);
    wr_data = 8'hFF; @(negedge clk);
    checkOutput("burst start fall", tx, 1'b0);
    wr_data = 8'h00; @(negedge clk);
    wr_en = 1'b0;
    checkOutput("burst full (pop already taken)", full, 1'b0);
    checkOutput("burst empty", empty, 1'b0);
    sampleFrame(8'hA5, 1'b0, "burst0", nt);
    checkOutput("burst0 back-to-back start", nt, 1'b0);
    checkOutput("burst0 busy held", busy, 1'b1);
    sampleFrame(8'h3C, 1'b0, "burst1", nt);
    checkOutput("burst1 back-to-back start", nt, 1'b0);
    sampleFrame(8'hFF, 1'b0, "burst2", nt);
    checkOutput("burst2 back-to-back start", nt, 1'b0);
    sampleFrame(8'h00, 1'b0, "burst3", nt);
    checkOutput("burst3 line idle after", nt, 1'b1);
    waitCycles(1);
    checkCount("burst tx_done pulses", done_count - done_start, 4);
    checkOutput("burst busy fall", busy, 1'b0);
    waitCycles(3);

    $display("[TB] overflow");
    full_seq = 5'b11000;
    ovf_seq  = 5'b10000;
    applyStimulus(8'h11);
    waitCycles(2);
    wr_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wr_data = 8'(8'h21 + k);
      @(negedge clk);
      checkOutput($sformatf("ovf push%0d full", k), full, full_seq[k]);
      checkOutput($sformatf("ovf push%0d overflow", k), overflow, ovf_seq[k]);
    end
    wr_en = 1'b0;
    waitCycles(10 * FB - 4);
    checkOutput("ovf full after pop", full, 1'b0);
    sampleFrame(8'h21, 1'b0, "ovf0", nt);
    checkOutput("ovf0 next start", nt, 1'b0);
    sampleFrame(8'h22, 1'b0, "ovf1", nt);
    checkOutput("ovf1 next start", nt, 1'b0);
    sampleFrame(8'h23, 1'b1, "ovf2", nt);
    checkOutput("ovf2 next start", nt, 1'b0);
    sampleFrame(8'h24, 1'b0, "ovf3", nt);
    checkOutput("ovf3 dropped word not sent", nt, 1'b1);
    checkOutput("ovf busy fall", busy, 1'b0);
    checkOutput("ovf empty", empty, 1'b1);
    checkOutput("ovf sticky", overflow, 1'b1);
    waitCycles(30);
    checkOutput("ovf line stays idle", tx, 1'b1);
    checkOutput("ovf sticky later", overflow, 1'b1);

    $display("[TB] reset mid-frame");
    wr_en = 1'b1; wr_data = 8'h55; @(negedge clk);
    wr_data = 8'h33; @(negedge clk);
    wr_en = 1'b0;
    waitCycles(45);
    checkOutput("pre-reset data bit3", tx, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset tx", tx, 1'b1);
    checkOutput("mid reset busy", busy, 1'b0);
    checkOutput("mid reset empty", empty, 1'b1);
    checkOutput("mid reset overflow", overflow, 1'b0);
    waitCycles(2);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) stray++;
    end
    checkCount("no residual frame after reset", stray, 0);

    $display("[TB] two stop bits");
    wr_en2 = 1'b1; wr_data2 = 8'h01; @(negedge clk);
    wr_en2 = 1'b0;
    waitCycles(10 * FB - 9);
    checkOutput("stop2 bit before stop", tx2, PRE_STOP_01);
    waitCycles(1);
    checkOutput("stop2 stop start", tx2, 1'b1);
    waitCycles(10);
    checkOutput("stop2 second stop bit level", tx2, 1'b1);
    checkOutput("stop2 no tx_done after one stop", tx_done2, 1'b0);
    waitCycles(8);
    checkOutput("stop2 tx_done not early", tx_done2, 1'b0);
    waitCycles(1);
    checkOutput("stop2 tx_done", tx_done2, 1'b1);
    checkOutput("stop2 busy at end", busy2, 1'b1);
    waitCycles(1);
    checkOutput("stop2 tx_done width", tx_done2, 1'b0);
    checkOutput("stop2 busy fall", busy2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
